freq_gen: RTL
=============

Name: freq_gen

Overview:
- Programmable square-wave generator; the generating counterpart of the clock-frequency measurement logic.
- Produces a signal of exactly N iCLK cycles per period and a one-cycle tick per period.
- Drives a known frequency onto test points, or into a frequency-check block for self-test.
- Divisor updates are glitch-free: they take effect only on a period boundary.

Parameters:
CNT_W, 24, width of divisor and internal counter
DEF_DIV, 24'd100, divisor loaded at reset; must be >= 2

Ports:
iCLK  input  1  system clock
iRST_N  input  1  asynchronous active-low reset
iEnable  input  1  level; 1 = run, 0 = stop after the current period
iDivLoad  input  1  one-cycle strobe; requests a new divisor
iDivVal  input  CNT_W  requested divisor N (period in iCLK cycles), sampled with iDivLoad
oSigOut  output  1  generated square wave, registered
oTick  output  1  one-cycle pulse in the first high cycle of every period
oBusy  output  1  1 while not in IDLE
oDivAck  output  1  one-cycle pulse when a pending divisor becomes active
oCurDiv  output  CNT_W  active divisor

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except oCurDiv=DEF_DIV; pending flag cleared.
- Clamp: iDivVal of 0 or 1 is stored as 2. No other range checks.
- Phase lengths for active divisor N:
  - H = (N+1)>>1 (high phase)
  - L = N>>1 (low phase)
  - Period is exactly N cycles. Odd N gives a high phase one cycle longer than the low phase.
- State IDLE:
  - oSigOut=0.
  - If iEnable=1: apply any pending divisor (pulse oDivAck), go to HIGH, load cnt=H-1.
  - oSigOut=1 and oTick=1 on the first HIGH cycle, i.e. one cycle after iEnable is sampled high.
- State HIGH:
  - oSigOut=1; cnt decrements each cycle.
  - At cnt==0: go to LOW, load cnt=L-1.
- State LOW:
  - oSigOut=0; cnt decrements each cycle.
  - At cnt==0 (period boundary):
    - If iEnable=1: apply any pending divisor (pulse oDivAck in the boundary cycle), go to HIGH with H/L of the new divisor.
    - Otherwise go to IDLE.
- Stop: deasserting iEnable never truncates a period. No runt pulses, no extended pulses.
- Divisor load:
  - iDivLoad captures the clamped iDivVal into the pending register and sets the pending flag.
  - If in IDLE: applied the next cycle with oDivAck, even if iEnable=0.
  - Otherwise: applied at the next period boundary.
- Simultaneous events:
  - iDivLoad in the same cycle as a boundary: the new value is applied at the following boundary, not this one.
  - Second iDivLoad before apply: overwrites the pending value; only one oDivAck results.
- oCurDiv updates in the same cycle oDivAck is high.
- Counter never wraps: it is reloaded before reaching 0-1.
- Reset mid-operation: immediate return to reset values; the pending load is lost.

Optional Feature:
FREQ_GEN_BURST_EN
- Defined:
  - Adds input iBurstLen (16 bits) and output oBurstDone (1 bit).
  - Leaving IDLE latches iBurstLen; 0 is treated as 1.
  - After that many complete periods the block returns to IDLE regardless of iEnable.
  - oBurstDone pulses one cycle in the final boundary cycle.
  - A new burst needs iEnable low for at least one cycle, then high again.
- Undefined: ports absent; output is continuous while iEnable=1.

Test Plan:
- Reset, iEnable=1, DEF_DIV=100 -> oSigOut high 50 / low 50 cycles repeating; oTick every 100 cycles; first oTick 1 cycle after iEnable.
- iDivVal=7 loaded while IDLE -> oDivAck next cycle, oCurDiv=7; running gives high 4 / low 3, period 7.
- Running at N=10, load 20 mid-high-phase -> current period stays 10 cycles; oDivAck at boundary; next periods high 10 / low 10.
- Load 1 -> clamped to 2 (toggle every cycle). Two loads (6 then 8) inside one period -> single oDivAck, oCurDiv=8.
- iEnable drops 3 cycles into a 10-cycle period -> period completes (7 more cycles), oBusy falls, oSigOut stays 0. iRST_N pulsed mid-high -> oSigOut=0 immediately.
- With FREQ_GEN_BURST_EN, N=4, iBurstLen=3 -> exactly 3 oTick, oBurstDone at cycle 12, IDLE despite iEnable=1.

Source files
------------

// File: rtl/freq_gen.sv
// freq_gen: programmable square wave of N clocks per period with glitch-free divisor updates.
// Optional FREQ_GEN_BURST_EN: stop after a latched number of periods.
module freq_gen #(
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] DEF_DIV = 24'd100
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iEnable,
  input  logic             iDivLoad,
  input  logic [CNT_W-1:0] iDivVal,
`ifdef FREQ_GEN_BURST_EN
  input  logic [15:0]      iBurstLen,
  output logic             oBurstDone,
`endif
  output logic             oSigOut,
  output logic             oTick,
  output logic             oBusy,
  output logic             oDivAck,
  output logic [CNT_W-1:0] oCurDiv
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_val_q, pend_val_d;
  logic [CNT_W-1:0] load_val, new_div;
  logic pend_q, pend_d, tick_q, tick_d, ack_q, ack_d;
  logic idle, boundary, start, cont, apply_pend, idle_load, armed, last;
`ifdef FREQ_GEN_BURST_EN
  logic [15:0] left_q, left_d;
  logic armed_q, armed_d;
  assign armed = armed_q;
  assign last = boundary && left_q == 16'd1;
  assign oBurstDone = last;
  assign armed_d = !iEnable || (armed_q && !last);
  assign left_d = start ? ((iBurstLen == 16'd0) ? 16'd1 : iBurstLen) : (cont ? left_q - 16'd1 : left_q);
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      left_q  <= '0;
      armed_q <= 1'b1;
    end else begin
      left_q  <= left_d;
      armed_q <= armed_d;
    end
`else
  assign armed = 1'b1;
  assign last = 1'b0;
`endif
  assign load_val = (iDivVal < TWO) ? TWO : iDivVal;
  assign idle = state_q == IDLE;
  assign boundary = state_q == LOW && cnt_q == '0;
  assign start = idle && iEnable && armed;
  assign cont = boundary && iEnable && !last;
  // a pending divisor only lands while idle or when a new period begins
  assign apply_pend = pend_q && (idle || cont);
  assign idle_load = idle && iDivLoad;
  assign new_div = idle_load ? load_val : (apply_pend ? pend_val_q : cur_q);
  assign cur_d = new_div;
  assign ack_d = idle_load || apply_pend;
  assign tick_d = start || cont;
  assign pend_d = idle_load ? 1'b0 : (iDivLoad ? 1'b1 : (apply_pend ? 1'b0 : pend_q));
  assign pend_val_d = iDivLoad ? load_val : pend_val_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - ONE;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = HIGH;
          cnt_d = (new_div - ONE) >> 1;
        end
      end
      HIGH: if (cnt_q == '0) begin
        state_d = LOW;
        cnt_d = (cur_q >> 1) - ONE;
      end
      LOW: if (cnt_q == '0) begin
        state_d = cont ? HIGH : IDLE;
        cnt_d = cont ? (new_div - ONE) >> 1 : '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_q      <= DEF_DIV;
      pend_val_q <= DEF_DIV;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  assign oSigOut = state_q == HIGH;
  assign oBusy = !idle;
  assign oTick = tick_q;
  assign oDivAck = ack_q;
  assign oCurDiv = cur_q;
endmodule
